// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl shared types: FSM encoding, scoreboard width, flush default.
// No ports; imported by the interlock controller and its scoreboard.
package hazard_ctrl_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam int CNT_W     = 2;
  localparam int REG_W     = 5;
  localparam int FLUSH_DEF = 1;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side handshake bundle between the pipeline and hazard_ctrl.
// master: pipeline (drives ID/EX/MEM/WB status); slave: hazard_ctrl.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  logic             id_valid;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [REG_W-1:0] id_rd;
  logic             id_rwen;
  logic             id_serial;
  logic             ex_redirect;
  logic             lsu_busy;
  logic             wb_valid;
  logic [REG_W-1:0] wb_rd;
  logic             wb_rwen;
  logic             wb_serial;

  logic             pipe_stop;
  logic             inst_clear;
  logic             ex_bubble;
  logic             stall_all;
  logic             issue;
  logic             sb_busy;
  logic [31:0]      perf_stall;

  modport master (
    output id_valid, id_rs1, id_rs2,
    output id_rs1_used, id_rs2_used,
    output id_rd, id_rwen, id_serial,
    output ex_redirect, lsu_busy,
    output wb_valid, wb_rd, wb_rwen,
    output wb_serial,
    input  pipe_stop, inst_clear,
    input  ex_bubble, stall_all,
    input  issue, sb_busy, perf_stall
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2,
    input  id_rs1_used, id_rs2_used,
    input  id_rd, id_rwen, id_serial,
    input  ex_redirect, lsu_busy,
    input  wb_valid, wb_rd, wb_rwen,
    input  wb_serial,
    output pipe_stop, inst_clear,
    output ex_bubble, stall_all,
    output issue, sb_busy, perf_stall
  );

endinterface

// File: rtl/hazard_ctrl_scoreboard.sv
// hz_scoreboard: per-GPR in-flight write counts (x1..x31) plus serial flag.
// Ports: clk/rst_n, rs1/rs2/rd lookups, set/clr strobes, busy/sat/sb_busy.
module hz_scoreboard
  import hazard_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic [REG_W-1:0] rd,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_rd,
  input  logic             clr_en,
  input  logic [REG_W-1:0] clr_rd,
  input  logic             ser_set,
  input  logic             ser_clr,
  output logic             rs1_busy,
  output logic             rs2_busy,
  output logic             rd_sat,
  output logic             ser_flag,
  output logic             sb_busy
);

  logic [CNT_W-1:0] cnt [1:31];
  logic [31:0]      nz;
  logic [31:0]      sat;

  // x0 has no counter: never busy, never saturated.
  assign nz[0]  = 1'b0;
  assign sat[0] = 1'b0;

  genvar i;
  for (i = 1; i < 32; i++) begin : g_cnt
    localparam logic [REG_W-1:0] IDX = REG_W'(i);
    logic inc;
    logic dec;

    assign inc = set_en & (set_rd == IDX);
    assign dec = clr_en & (clr_rd == IDX);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt[i] <= '0;
      end else if (inc & !dec) begin
        cnt[i] <= cnt[i] + 1'b1;
      end else if (dec & !inc) begin
        cnt[i] <= cnt[i] - 1'b1;
      end
    end

    assign nz[i]  = |cnt[i];
    assign sat[i] = (cnt[i] == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ser_flag <= 1'b0;
    end else if (ser_set) begin
      ser_flag <= 1'b1;
    end else if (ser_clr) begin
      ser_flag <= 1'b0;
    end
  end

  assign rs1_busy = nz[rs1];
  assign rs2_busy = nz[rs2];
  assign rd_sat   = sat[rd];
  assign sb_busy  = (|nz) | ser_flag;

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage interlock: RAW/WAW/serial stalls, memory freeze, flush FSM.
// Ports: clk, rst_n (sync, active-low), bus (hazard_ctrl_if.slave).
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = FLUSH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave bus
);

  localparam logic [2:0] FLUSH_LD = 3'(FLUSH_CYCLES - 1);

  state_t      state;
  logic [2:0]  fcnt;
  logic [31:0] stall_cnt;

  logic rs1_busy;
  logic rs2_busy;
  logic rd_sat;
  logic ser_flag;
  logic sb_any;

  logic hazard;
  logic in_run;
  logic c_lsu;
  logic c_clr;
  logic c_hz;
  logic c_go;

  logic pipe_stop;
  logic inst_clear;
  logic ex_bubble;
  logic stall_all;
  logic issue;

  logic sb_set;
  logic sb_clr;
  logic ser_set;
  logic ser_clr;

  hz_scoreboard u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1      (bus.id_rs1),
    .rs2      (bus.id_rs2),
    .rd       (bus.id_rd),
    .set_en   (sb_set),
    .set_rd   (bus.id_rd),
    .clr_en   (sb_clr),
    .clr_rd   (bus.wb_rd),
    .ser_set  (ser_set),
    .ser_clr  (ser_clr),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_sat   (rd_sat),
    .ser_flag (ser_flag),
    .sb_busy  (sb_any)
  );

  // Counts stay busy through the WB cycle: the regfile write lands
  // at the edge, so the consumer must wait one more cycle.
  assign hazard = bus.id_valid & (
      (bus.id_rs1_used & rs1_busy)
    | (bus.id_rs2_used & rs2_busy)
    | (bus.id_rwen & rd_sat)
    | (bus.id_serial & sb_any)
    | ser_flag);

  assign in_run = (state == RUN);

  // One-hot priority terms; reset kills every output.
  assign c_lsu = rst_n & bus.lsu_busy;
  assign c_clr = rst_n & !bus.lsu_busy
               & (bus.ex_redirect | !in_run);
  assign c_hz  = rst_n & !bus.lsu_busy
               & !bus.ex_redirect & in_run & hazard;
  assign c_go  = rst_n & !bus.lsu_busy
               & !bus.ex_redirect & in_run & !hazard;

  always_comb begin
    pipe_stop  = 1'b0;
    inst_clear = 1'b0;
    ex_bubble  = 1'b0;
    stall_all  = 1'b0;
    issue      = 1'b0;
    unique case (1'b1)
      c_lsu: begin
        pipe_stop = 1'b1;
        stall_all = 1'b1;
      end
      c_clr: begin
        inst_clear = 1'b1;
        ex_bubble  = 1'b1;
      end
      c_hz: begin
        pipe_stop = 1'b1;
        ex_bubble = 1'b1;
      end
      c_go: begin
        issue = bus.id_valid;
      end
      default: ;
    endcase
  end

  assign sb_set  = issue & bus.id_rwen & (bus.id_rd != '0);
  assign sb_clr  = bus.wb_valid & bus.wb_rwen & !stall_all
                 & (bus.wb_rd != '0);
  assign ser_set = issue & bus.id_serial;
  assign ser_clr = bus.wb_valid & bus.wb_serial & !stall_all;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      fcnt      <= '0;
      stall_cnt <= '0;
    end else begin
      if (pipe_stop) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      // A frozen EX re-presents its redirect, so ignore it here.
      if (!bus.lsu_busy) begin
        unique case (state)
          RUN: begin
            if (bus.ex_redirect && FLUSH_CYCLES > 1) begin
              state <= FLUSH;
              fcnt  <= FLUSH_LD;
            end
          end
          FLUSH: begin
            if (bus.ex_redirect) begin
              fcnt <= FLUSH_LD;
            end else if (fcnt <= 3'd1) begin
              state <= RUN;
              fcnt  <= '0;
            end else begin
              fcnt <= fcnt - 3'd1;
            end
          end
          default: begin
            state <= RUN;
            fcnt  <= '0;
          end
        endcase
      end
    end
  end

  assign bus.pipe_stop  = pipe_stop;
  assign bus.inst_clear = inst_clear;
  assign bus.ex_bubble  = ex_bubble;
  assign bus.stall_all  = stall_all;
  assign bus.issue      = issue;
  assign bus.sb_busy    = rst_n & sb_any;
  assign bus.perf_stall = rst_n ? stall_cnt : '0;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with FLUSH_CYCLES=2.
// Output vector order: {pipe_stop, inst_clear, ex_bubble, stall_all, issue, sb_busy}.
module tb_hazard_ctrl;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  hazard_ctrl_if ifc ();

  hazard_ctrl #(
    .FLUSH_CYCLES(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {ifc.pipe_stop, ifc.inst_clear, ifc.ex_bubble,
            ifc.stall_all, ifc.issue, ifc.sb_busy};
  endfunction

  task automatic co(input string tag, input logic [5:0] exp);
    #1;
    chk(tag, {26'd0, outs()}, {26'd0, exp});
  endtask

  task automatic cp(input string tag, input logic [31:0] exp);
    #1;
    chk(tag, ifc.perf_stall, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifc.id_valid    = 1'b0;
    ifc.id_rs1      = '0;
    ifc.id_rs2      = '0;
    ifc.id_rs1_used = 1'b0;
    ifc.id_rs2_used = 1'b0;
    ifc.id_rd       = '0;
    ifc.id_rwen     = 1'b0;
    ifc.id_serial   = 1'b0;
    ifc.ex_redirect = 1'b0;
    ifc.lsu_busy    = 1'b0;
    ifc.wb_valid    = 1'b0;
    ifc.wb_rd       = '0;
    ifc.wb_rwen     = 1'b0;
    ifc.wb_serial   = 1'b0;
  endtask

  task automatic id_inst(input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd, input logic we);
    ifc.id_valid    = 1'b1;
    ifc.id_rs1      = rs1;
    ifc.id_rs1_used = u1;
    ifc.id_rs2      = rs2;
    ifc.id_rs2_used = u2;
    ifc.id_rd       = rd;
    ifc.id_rwen     = we;
    ifc.id_serial   = 1'b0;
  endtask

  task automatic wb_wr(input logic [4:0] rd);
    ifc.wb_valid  = 1'b1;
    ifc.wb_rd     = rd;
    ifc.wb_rwen   = 1'b1;
    ifc.wb_serial = 1'b0;
  endtask

  task automatic wb_off();
    ifc.wb_valid  = 1'b0;
    ifc.wb_rwen   = 1'b0;
    ifc.wb_serial = 1'b0;
    ifc.wb_rd     = '0;
  endtask

  // A retiring write must always find its count nonzero.
  always @(negedge clk) begin
    if (rst_n && ifc.wb_valid && ifc.wb_rwen
        && !ifc.stall_all && ifc.wb_rd != 5'd0) begin
      total++;
      assert (dut.u_sb.nz[ifc.wb_rd] === 1'b1) else begin
        bad++;
        $error("FAIL underflow rd=%0d got=0 exp=1", ifc.wb_rd);
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    idle();
    rst_n = 1'b0;
    ifc.id_valid    = 1'b1;
    ifc.lsu_busy    = 1'b1;
    ifc.ex_redirect = 1'b1;
    co("rst_outs_pre", 6'b000000);
    tick();
    co("rst_outs", 6'b000000);
    cp("rst_perf", 32'd0);
    tick();
    idle();
    rst_n = 1'b1;
    co("idle", 6'b000000);
    tick();

    // back-to-back RAW on x5
    id_inst(5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1);
    co("raw_prod", 6'b000010);
    tick();
    id_inst(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1);
    co("raw_ex", 6'b101001);
    tick();
    co("raw_mem", 6'b101001);
    tick();
    wb_wr(5'd5);
    co("raw_wb", 6'b101001);
    tick();
    wb_off();
    co("raw_rel", 6'b000010);
    cp("raw_perf", 32'd3);
    tick();
    idle();
    wb_wr(5'd6);
    co("x6_wb", 6'b000001);
    tick();
    wb_off();
    co("x6_gone", 6'b000000);

    // x0 and unused sources
    id_inst(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    co("x0_prod", 6'b000010);
    tick();
    id_inst(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0);
    co("x0_cons", 6'b000010);
    tick();
    id_inst(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
    co("x7_prod", 6'b000010);
    tick();
    id_inst(5'd3, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0);
    co("x7_unused", 6'b000011);
    tick();
    id_inst(5'd3, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0);
    co("x7_used", 6'b101001);
    tick();
    idle();
    wb_wr(5'd7);
    co("x7_wb", 6'b000001);
    tick();
    wb_off();
    co("x7_gone", 6'b000000);
    cp("x_perf", 32'd4);

    // redirect, two flush cycles
    id_inst(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    ifc.ex_redirect = 1'b1;
    co("redir", 6'b011000);
    tick();
    ifc.ex_redirect = 1'b0;
    co("flush", 6'b011000);
    tick();
    co("flush_done", 6'b000010);
    cp("redir_perf", 32'd4);

    // memory freeze with x9 in WB
    id_inst(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
    co("x9_prod", 6'b000010);
    tick();
    idle();
    wb_wr(5'd9);
    ifc.lsu_busy = 1'b1;
    co("frz1", 6'b100101);
    tick();
    ifc.ex_redirect = 1'b1;
    co("frz2_redir", 6'b100101);
    tick();
    ifc.ex_redirect = 1'b0;
    co("frz3", 6'b100101);
    tick();
    co("frz4", 6'b100101);
    tick();
    ifc.lsu_busy = 1'b0;
    co("frz_wb", 6'b000001);
    tick();
    wb_off();
    co("frz_after", 6'b000000);
    cp("frz_perf", 32'd8);

    // serialization
    id_inst(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1);
    co("ser_w10", 6'b000010);
    tick();
    id_inst(5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1);
    co("ser_w11", 6'b000011);
    tick();
    id_inst(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    ifc.id_serial = 1'b1;
    co("csr_wait", 6'b101001);
    tick();
    wb_wr(5'd10);
    co("csr_wb10", 6'b101001);
    tick();
    wb_wr(5'd11);
    co("csr_wb11", 6'b101001);
    tick();
    wb_off();
    co("csr_issue", 6'b000010);
    tick();
    ifc.id_serial = 1'b0;
    co("post_csr", 6'b101001);
    tick();
    ifc.wb_valid  = 1'b1;
    ifc.wb_serial = 1'b1;
    co("csr_ret", 6'b101001);
    tick();
    wb_off();
    co("post_rel", 6'b000010);
    cp("ser_perf", 32'd13);

    // WAW cap on x12
    id_inst(5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1);
    co("waw1", 6'b000010);
    tick();
    co("waw2", 6'b000011);
    tick();
    co("waw3", 6'b000011);
    tick();
    co("waw_cap", 6'b101001);
    tick();
    wb_wr(5'd12);
    co("waw_wb", 6'b101001);
    tick();
    wb_off();
    co("waw_rel", 6'b000011);
    cp("waw_perf", 32'd15);
    tick();

    // reset while x12 count is 2
    idle();
    wb_wr(5'd12);
    tick();
    wb_off();
    id_inst(5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    co("rst_stall", 6'b101001);
    rst_n = 1'b0;
    co("rst_mid", 6'b000000);
    cp("rst_mid_perf", 32'd0);
    tick();
    rst_n = 1'b1;
    co("rst_issue", 6'b000010);
    cp("rst_perf2", 32'd0);
    tick();
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
